// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory (combinational read, write on
// the clock edge) between the core load/store unit (m0) and a debug/DMA loader (m1).
//
// Arbitration is sticky: the last requester granted keeps the port. When the other
// requester waits, the owner may take at most MAX_HOLD grants in a row before the
// port moves. Read data is registered and returned one cycle after the grant, with
// a one-cycle rvalid pulse on the requester that issued the read.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority. m0 always wins,
// there is no hold counter, and m1 can starve.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   mX_req/we/addr/wdata    request from requester X; req is held until granted
//   mX_gnt                  request accepted this cycle (combinational)
//   mX_rvalid/rdata         registered read response, one cycle after the grant
//   mem_addr/we/wdata       to memory; m0's addr/wdata when nothing is granted
//   mem_rd                  combinational read data from memory
//   busy                    a grant is issued this cycle
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic          gnt0, gnt1;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;

  // hold counts consecutive grants to the owner taken while the other waits.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req) begin
          gnt0    = 1'b1;
          state_d = StOwn0;
          hold_d  = m1_req ? HW'(1) : '0;
        end else if (m1_req) begin
          gnt1    = 1'b1;
          state_d = StOwn1;
          hold_d  = '0;
        end else begin
          hold_d  = '0;
        end
      end
      StOwn0: begin
        if (m0_req && (!m1_req || hold_q < HoldMax)) begin
          gnt0   = 1'b1;
          hold_d = m1_req ? hold_q + HW'(1) : '0;
        end else if (m1_req) begin
          gnt1    = 1'b1;
          state_d = StOwn1;
          hold_d  = m0_req ? HW'(1) : '0;
        end else begin
          state_d = StIdle;
          hold_d  = '0;
        end
      end
      StOwn1: begin
        if (m1_req && (!m0_req || hold_q < HoldMax)) begin
          gnt1   = 1'b1;
          hold_d = m0_req ? hold_q + HW'(1) : '0;
        end else if (m0_req) begin
          gnt0    = 1'b1;
          state_d = StOwn0;
          hold_d  = m1_req ? HW'(1) : '0;
        end else begin
          state_d = StIdle;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Fixed priority; state only records who used the port last.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = StIdle;
    if (m0_req) begin
      gnt0    = 1'b1;
      state_d = StOwn0;
    end else if (m1_req) begin
      gnt1    = 1'b1;
      state_d = StOwn1;
    end
  end
`endif

  // Grants are combinational, so they must be masked while reset is held low.
  assign m0_gnt    = gnt0 & reset;
  assign m1_gnt    = gnt1 & reset;
  assign busy      = m0_gnt | m1_gnt;
  assign mem_addr  = m1_gnt ? m1_addr : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign mem_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= m0_gnt & ~m0_we;
      rvalid1_q <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) rdata0_q <= mem_rd;
      if (m1_gnt && !m1_we) rdata1_q <= mem_rd;
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference arbiter/memory model predicts each
// cycle's grant and pushes expected read responses; a monitor pops and compares them.
module tb_dmem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, busy;
  logic [DW-1:0] mem_wdata, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .busy(busy)
  );

  // Bench data memory: 16 words, combinational read, write on the edge.
  logic [DW-1:0] ram [16];
  bit            ram_init = 1'b0;
  assign mem_rd = ram[mem_addr[3:0]];
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0101_0101 * i;
      ram_init <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr[3:0]] <= mem_wdata;
    end
  end

  // Reference model state.
  typedef struct {int due; logic [DW-1:0] data;} resp_t;
  logic [DW-1:0] ref_mem [16];
  resp_t         q0[$], q1[$];
  logic [DW-1:0] last0, last1;
  int            owner, streak;
  int            checks, errors, cyc;
  bit            done;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    streak = 0;
    q0.delete();
    q1.delete();
    last0  = '0;
    last1  = '0;
  endtask

  task automatic drive(input int p, input bit r, input bit we, input logic [3:0] a,
                       input logic [DW-1:0] d);
    if (p == 0) begin
      m0_req = r; m0_we = we; m0_addr = {{(AW-4){1'b0}}, a}; m0_wdata = d;
    end else begin
      m1_req = r; m1_we = we; m1_addr = {{(AW-4){1'b0}}, a}; m1_wdata = d;
    end
  endtask

  // At mid-cycle: predict the winner from the requests, check the port, update model.
  task automatic check_cycle(output bit g0, output bit g1);
    int            w;
    bit            r0, r1, ro, rx, oth;
    bit            we;
    logic [3:0]    a;
    logic [DW-1:0] d;
    @(negedge clk);
    r0 = m0_req;
    r1 = m1_req;
    w  = -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (r0) w = 0;
    else if (r1) w = 1;
`else
    if (owner < 0) begin
      if (r0) w = 0;
      else if (r1) w = 1;
    end else begin
      ro = (owner == 0) ? r0 : r1;
      rx = (owner == 0) ? r1 : r0;
      if (ro && (!rx || streak < MAX_HOLD)) w = owner;
      else if (rx) w = 1 - owner;
    end
    if (w < 0) begin
      owner  = -1;
      streak = 0;
    end else begin
      oth = (w == 0) ? r1 : r0;
      if (w != owner) begin
        owner  = w;
        streak = oth ? 1 : 0;
      end else begin
        streak = oth ? ((streak + 1 > MAX_HOLD) ? MAX_HOLD : streak + 1) : 0;
      end
    end
`endif
    chk("m0_gnt", m0_gnt, w == 0);
    chk("m1_gnt", m1_gnt, w == 1);
    chk("gnt_onehot", m0_gnt & m1_gnt, 0);
    chk("busy", busy, w >= 0);
    we = (w == 1) ? m1_we : m0_we;
    a  = (w == 1) ? m1_addr[3:0] : m0_addr[3:0];
    d  = (w == 1) ? m1_wdata : m0_wdata;
    chk("mem_we", mem_we, (w >= 0) && we);
    chk("mem_addr", mem_addr, (w == 1) ? m1_addr : m0_addr);
    chk("mem_wdata", mem_wdata, d);
    if (w >= 0) begin
      if (we) ref_mem[a] = d;
      else if (w == 0) q0.push_back('{due: cyc + 1, data: ref_mem[a]});
      else q1.push_back('{due: cyc + 1, data: ref_mem[a]});
    end
    g0 = (w == 0);
    g1 = (w == 1);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Monitor: rvalid must pulse exactly when a response is due; rdata holds otherwise.
  initial begin
    bit e0, e1;
    forever begin
      @(posedge clk);
      #3;
      if (done) break;
      e0 = (q0.size() > 0) && (q0[0].due == cyc);
      e1 = (q1.size() > 0) && (q1[0].due == cyc);
      chk("m0_rvalid", m0_rvalid, e0);
      chk("m1_rvalid", m1_rvalid, e1);
      if (e0) begin last0 = q0[0].data; void'(q0.pop_front()); end
      if (e1) begin last1 = q1[0].data; void'(q1.pop_front()); end
      chk("m0_rdata", m0_rdata, last0);
      chk("m1_rdata", m1_rdata, last1);
    end
  end

  initial begin
    bit g0, g1;
    int exp_w [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    checks = 0;
    errors = 0;
    done   = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0101_0101 * i;

    // Reset with both requesting: nothing may be granted or written.
    drive(0, 1, 1, 4'd7, 32'h1234_5678);
    drive(1, 1, 0, 4'd0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    advance();
    reset = 1'b1;
    check_cycle(g0, g1);
    chk("first_gnt_m0", m0_gnt, 1);

    // m0 writes 5 then reads it back.
    advance();
    drive(0, 1, 1, 4'd5, 32'hDEAD_BEEF);
    drive(1, 0, 0, 4'd0, '0);
    check_cycle(g0, g1);
    advance();
    drive(0, 1, 0, 4'd5, '0);
    check_cycle(g0, g1);
    advance();
    drive(0, 0, 0, 4'd0, '0);
    chk("wr_rd_rvalid", m0_rvalid, 1);
    chk("wr_rd_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("wr_rd_m1_rvalid", m1_rvalid, 0);
    check_cycle(g0, g1);

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Contention from IDLE: four grants each, then back.
    for (int i = 0; i < 9; i++) begin
      advance();
      drive(0, 1, 0, 4'(i), '0);
      drive(1, 1, 0, 4'(i + 8), '0);
      check_cycle(g0, g1);
      chk("contend_seq", m1_gnt, exp_w[i]);
    end
`else
    for (int i = 0; i < 10; i++) begin
      advance();
      drive(0, 1, 0, 4'(i), '0);
      drive(1, 1, 0, 4'(i + 2), '0);
      check_cycle(g0, g1);
      chk("fixed_m0", m0_gnt, 1);
    end
    advance();
    drive(0, 0, 0, 4'd0, '0);
    check_cycle(g0, g1);
    chk("fixed_m1", m1_gnt, 1);
`endif
    advance();
    drive(0, 0, 0, 4'd0, '0);
    drive(1, 0, 0, 4'd0, '0);
    check_cycle(g0, g1);

    // m0 writes 3, m1 reads it the following cycle.
    advance();
    drive(0, 1, 1, 4'd3, 32'h0000_0011);
    check_cycle(g0, g1);
    advance();
    drive(0, 0, 0, 4'd0, '0);
    drive(1, 1, 0, 4'd3, '0);
    check_cycle(g0, g1);
    advance();
    drive(1, 0, 0, 4'd0, '0);
    chk("coherent_rvalid", m1_rvalid, 1);
    chk("coherent_rdata", m1_rdata, 32'h0000_0011);
    check_cycle(g0, g1);

    // Reset between an m1 read grant and its response edge.
    advance();
    drive(1, 1, 0, 4'd4, '0);
    check_cycle(g0, g1);
    #1;
    reset = 1'b0;
    model_reset();
    drive(1, 0, 0, 4'd0, '0);
    drive(0, 1, 1, 4'd9, 32'hCAFE_F00D);
    #1;
    chk("midrst_m0_gnt", m0_gnt, 0);
    chk("midrst_mem_we", mem_we, 0);
    advance();
    chk("midrst_rvalid", m1_rvalid, 0);
    drive(0, 0, 0, 4'd0, '0);
    advance();
    reset = 1'b1;
    check_cycle(g0, g1);
    chk("post_rst_busy", busy, 0);

    // Random traffic; each requester holds its transaction until granted.
    g0 = 1'b1;
    g1 = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      advance();
      if (g0 || !m0_req)
        drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), $urandom);
      if (g1 || !m1_req)
        drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), $urandom);
      check_cycle(g0, g1);
    end

    advance();
    drive(0, 0, 0, 4'd0, '0);
    drive(1, 0, 0, 4'd0, '0);
    repeat (3) begin
      check_cycle(g0, g1);
      advance();
    end
    done = 1'b1;
    @(posedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
